// File: rtl/fft_corner_turn_pkg.sv
// Shared definitions for the FFT corner-turn (frame transpose) block.
// Holds the FSM state encoding, the default frame size and sample width,
// and the bit positions of the real/imaginary fields inside a sample.
package fft_corner_turn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } ct_state_t;

    localparam int CT_N_DEFAULT      = 128;
    localparam int CT_DATA_W_DEFAULT = 32;

    // Complex sample layout: imaginary in the upper half, real in the lower half.
    localparam int CT_RE_LSB = 0;
    localparam int CT_RE_MSB = CT_DATA_W_DEFAULT / 2 - 1;
    localparam int CT_IM_LSB = CT_DATA_W_DEFAULT / 2;
    localparam int CT_IM_MSB = CT_DATA_W_DEFAULT - 1;

endpackage

// File: rtl/ct_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered output (1-cycle read latency). No reset on the array or the
// read register so the storage maps onto block RAM.
// Ports:
//   clk      clock
//   wr_en    write strobe, wr_addr/wr_data written at the rising edge
//   rd_en    read strobe, rd_data updated at the rising edge from rd_addr
module ct_sdp_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_corner_turn.sv
// Corner turn between two 1D FFT passes: accepts an N x N frame of complex
// samples in row-major order, then emits it in column-major order (exact
// transpose, no arithmetic on the data).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   s_tdata/tvalid/tlast    row-major input stream, s_tready back-pressure
//   m_tdata/tvalid/tlast    column-major output stream, m_tready from sink
//   busy                    frame in progress (FILL or DRAIN)
//   frame_done              one-cycle pulse after the last output handshake
//   err_tlast               one-cycle pulse when s_tlast disagrees with the column count
//   fsm_state               current FSM state, for observation
//
// Handshake rule on both streams: a beat transfers exactly at a rising edge
// where tvalid and tready are both high; otherwise nothing moves.
module fft_corner_turn
    import fft_corner_turn_pkg::*;
#(
    parameter int N      = CT_N_DEFAULT,
    parameter int DATA_W = CT_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              busy,
    output logic              frame_done,
    output logic              err_tlast,
    output ct_state_t         fsm_state
);

    localparam int LOG = $clog2(N);
    localparam int AW  = 2 * LOG;
    localparam logic [LOG-1:0] IDX_LAST  = LOG'(N - 1);
    localparam logic [AW-1:0]  BEAT_LAST = AW'(N * N - 1);

    ct_state_t         state;
    logic [LOG-1:0]    row, col;
    logic [AW-1:0]     rd_k;      // next output beat index to read
    logic [AW-1:0]     out_k;     // output beats handed off so far
    logic              rd_done;   // all N*N reads issued for this frame
    logic              rd_pend;   // RAM data arrives this cycle
    logic              last_pend; // tlast flag travelling with rd_pend
    logic [DATA_W-1:0] rd_data;

    // Two-entry output skid FIFO, each entry {last, data}.
    logic [DATA_W:0]   skid [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;

    logic              in_hs, pop, rd_en;
    logic [2:0]        occ_next;
    logic [AW-1:0]     rd_addr;

    assign in_hs     = s_tvalid && s_tready;
    assign pop       = m_tvalid && m_tready;
    assign s_tready  = (state != ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;
    assign m_tvalid  = (count != 2'd0);
    assign {m_tlast, m_tdata} = skid[rd_ptr];

    // Occupancy after this edge. A read issued now lands one cycle later, so
    // it is only safe if one slot remains even when nothing pops next cycle.
    // With m_tready high this still sustains one read per cycle.
    assign occ_next = {1'b0, count} + {2'b0, rd_pend} - {2'b0, pop};
    assign rd_en    = (state == ST_DRAIN) && !rd_done && (occ_next <= 3'd1);

    // Beat k = {k_hi, k_lo} reads address k_lo*N + k_hi: swap the halves.
    assign rd_addr  = {rd_k[LOG-1:0], rd_k[AW-1:LOG]};

    ct_sdp_ram #(
        .ADDR_W (AW),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_hs),
        .wr_addr ({row, col}),
        .wr_data (s_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            rd_k       <= '0;
            out_k      <= '0;
            rd_done    <= 1'b0;
            rd_pend    <= 1'b0;
            last_pend  <= 1'b0;
            skid[0]    <= '0;
            skid[1]    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            frame_done <= 1'b0;
            err_tlast  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_tlast  <= 1'b0;

            // Row boundaries come from the column counter only; s_tlast is
            // just checked. Counters wrap naturally since N is a power of two.
            if (in_hs) begin
                err_tlast <= (s_tlast != (col == IDX_LAST));
                col       <= col + 1'b1;
                if (col == IDX_LAST) row <= row + 1'b1;
            end

            rd_pend <= rd_en;
            if (rd_en) begin
                rd_k      <= rd_k + 1'b1;
                last_pend <= (rd_k[LOG-1:0] == IDX_LAST);
                if (rd_k == BEAT_LAST) rd_done <= 1'b1;
            end

            if (rd_pend) begin
                skid[wr_ptr] <= {last_pend, rd_data};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                out_k  <= out_k + 1'b1;
            end
            count <= occ_next[1:0];

            case (state)
                ST_IDLE: begin
                    if (in_hs) state <= ST_FILL;
                end
                ST_FILL: begin
                    if (in_hs && row == IDX_LAST && col == IDX_LAST) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && out_k == BEAT_LAST) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                        rd_done    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fft_corner_turn.md
FFT_CORNER_TURN -- requirements
Module: fft_corner_turn

Interface
REQ-001 Parameter N, 128, frame side length; frame is N x N complex samples; power of two, 4..256.
REQ-002 Parameter DATA_W, 32, sample width; [DATA_W-1:DATA_W/2] imaginary, [DATA_W/2-1:0] real.
REQ-003 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 s_tdata  input  DATA_W  row-major sample from the 1D-FFT master port.
REQ-006 s_tvalid  input  1  input sample valid.
REQ-007 s_tlast  input  1  last sample of an input row.
REQ-008 s_tready  output  1  block accepts an input sample.
REQ-009 m_tdata  output  DATA_W  column-major sample to the second FFT slave port.
REQ-010 m_tvalid  output  1  output sample valid.
REQ-011 m_tlast  output  1  last sample of an output column.
REQ-012 m_tready  input  1  downstream accepts an output sample.
REQ-013 busy  output  1  high in FILL or DRAIN.
REQ-014 frame_done  output  1  one-cycle pulse after the last output handshake of a frame.
REQ-015 err_tlast  output  1  one-cycle pulse on an input tlast mismatch.

Function
REQ-016 The block SHALL implement states IDLE, FILL and DRAIN.
- IDLE -> FILL on the first accepted input beat.
- FILL -> DRAIN on acceptance of beat N*N-1.
- DRAIN -> IDLE on the handshake of output beat N*N-1.
REQ-017 A handshake SHALL occur only when tvalid and tready are both high at a rising edge.
REQ-018 s_tready SHALL be high in IDLE and FILL and low in DRAIN.
REQ-019 An input beat with row r and column c SHALL be written to buffer address r*N+c.
REQ-020 Row and column counters SHALL be log2(N) bits and wrap to 0 at N-1.
REQ-021 Output beat k SHALL carry the buffer word at address (k mod N)*N + (k div N), i.e. the exact transpose with no arithmetic on the data.
REQ-022 m_tlast SHALL be high on output beats where k mod N = N-1.
REQ-023 Buffer read latency SHALL be 1 cycle.
REQ-024 Output SHALL use a 2-entry skid buffer so that m_tvalid can stay high every cycle while m_tready is high.
REQ-025 When m_tready is low, m_tdata and m_tlast SHALL be held stable and no output beat SHALL be lost or duplicated.
REQ-026 m_tvalid SHALL first go high on the 2nd rising edge after the last input handshake.
REQ-027 err_tlast SHALL pulse when s_tlast is high at column other than N-1, or low at column N-1.
REQ-028 Row boundaries SHALL follow the column counter, not s_tlast; the frame continues after an err_tlast pulse.
REQ-029 frame_done SHALL pulse on the cycle after the final output handshake, and the block SHALL accept the next frame from that cycle.
REQ-030 Input valid and output ready SHALL be mutually independent; a new frame starts only from IDLE.

Reset
REQ-031 On reset the block SHALL go to IDLE, clear counters and skid entries, and drive s_tready=1, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, frame_done=0, err_tlast=0.
REQ-032 Reset in FILL or DRAIN SHALL discard the partial frame; buffer contents need not be cleared.

Structure
REQ-033 A shared package SHALL hold the state enum, the default N and DATA_W, and the complex-sample field slice constants.
REQ-034 A sub-module ct_sdp_ram SHALL provide the buffer: simple dual-port, N*N x DATA_W, one write port and one registered read port, inferable as block RAM.

Verification
REQ-035 N=4 with data = address 0..15, tlast every 4th beat, m_tready=1 -> output order 0,4,8,12,1,5,...,15; m_tlast on output beats 3,7,11,15; one frame_done pulse.
REQ-036 N=128 with real=row, imag=col for 16384 beats -> output beat k has real=k mod 128 and imag=k div 128; m_tvalid first high 2 cycles after the last input handshake.
REQ-037 N=4 with m_tready toggled randomly at 50% -> output sequence identical to REQ-035, with no drops or duplicates and data stable while stalled.
REQ-038 N=4 with s_tlast on beat 2 of row 0 -> err_tlast pulses once and output is still the correct transpose.
REQ-039 N=4 with reset at input beat 7, then a full frame -> only the second frame is emitted, correctly transposed.
REQ-040 Two back-to-back N=4 frames with s_tvalid held high -> s_tready low through DRAIN; the second frame is accepted from the frame_done cycle and both transposes are correct.
